// File: rtl/external_interrupt_controller.sv
// External interrupt controller: edge-detects device and NMI lines, prioritises them,
// and runs the IntReq/IntId/IntAck handshake with a small memory-mapped register file.
module external_interrupt_controller #(
  parameter int          NUM_SRC   = 8,
  parameter logic [29:0] BASE_ADDR = 30'h0000_0100
) (
  input  logic               Sys_Clock,
  input  logic               Sys_Reset,
  input  logic [NUM_SRC-1:0] Src_Irq,
  input  logic               Nmi_Irq,
  input  logic               IO_EnR,
  input  logic               IO_EnW,
  input  logic [29:0]        IO_Address,
  input  logic [31:0]        IO_DataW,
  output logic [31:0]        IO_DataR,
  output logic               IO_Hit,
  output logic               EIC_IntReq,
  output logic               EIC_IntId,
  input  logic               EIC_IntAck,
  output logic [1:0]         o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ_DEV = 2'd1,
    ST_SERVICE = 2'd2,
    ST_REQ_NMI = 2'd3
  } state_t;

  state_t             r_state;
  logic [NUM_SRC-1:0] r_hist, r_pend, r_mask;
  logic               r_nmi_hist, r_nmi_pend;
  logic [3:0]         r_win, r_cur_idx;
  logic               r_cur_valid, r_ret_service;
  logic               r_int_req, r_int_id;
  logic [31:0]        r_data_r;
  logic               r_hit;

  logic [29:0]        w_off;
  logic               w_hit, w_wr_pend, w_wr_mask, w_wr_eoi;
  logic [NUM_SRC-1:0] w_edge, w_act, w_w1c, w_ack_clr;
  logic               w_nmi_edge, w_dev_ack, w_nmi_ack;
  logic [3:0]         w_win;
  logic [31:0]        w_rdata;
  logic               w_unused_data;

  // Unsigned wrap makes addresses below BASE_ADDR land far outside the 0..3 window.
  assign w_off     = IO_Address - BASE_ADDR;
  assign w_hit     = (w_off < 30'd4);
  assign w_wr_pend = IO_EnW && w_hit && (w_off[1:0] == 2'd0);
  assign w_wr_mask = IO_EnW && w_hit && (w_off[1:0] == 2'd1);
  assign w_wr_eoi  = IO_EnW && w_hit && (w_off[1:0] == 2'd3);

  assign w_edge     = Src_Irq & ~r_hist;
  assign w_nmi_edge = Nmi_Irq & ~r_nmi_hist;
  assign w_act      = r_pend & r_mask;
  assign w_dev_ack  = (r_state == ST_REQ_DEV) && EIC_IntAck;
  assign w_nmi_ack  = (r_state == ST_REQ_NMI) && EIC_IntAck;
  assign w_ack_clr  = w_dev_ack ? (NUM_SRC'(1) << r_win) : '0;
  assign w_w1c      = w_wr_pend ? IO_DataW[NUM_SRC-1:0] : '0;
  assign w_unused_data = &{1'b0, IO_DataW};

  always_comb begin
    w_win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_act[i]) w_win = 4'(i);
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_off[1:0])
      2'd0:    w_rdata = {{(32-NUM_SRC){1'b0}}, r_pend};
      2'd1:    w_rdata = {{(32-NUM_SRC){1'b0}}, r_mask};
      2'd2:    w_rdata = {r_cur_valid, 27'd0, r_cur_idx};
      default: w_rdata = '0;
    endcase
  end

  // Edge-set terms are OR-ed in last so a new edge beats a W1C or ack clear.
  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      r_hist     <= '0;
      r_nmi_hist <= 1'b0;
      r_pend     <= '0;
      r_nmi_pend <= 1'b0;
      r_mask     <= '0;
      r_data_r   <= '0;
      r_hit      <= 1'b0;
    end else begin
      r_hist     <= Src_Irq;
      r_nmi_hist <= Nmi_Irq;
      r_pend     <= (r_pend & ~(w_w1c | w_ack_clr)) | w_edge;
      r_nmi_pend <= (r_nmi_pend & ~w_nmi_ack) | w_nmi_edge;
      if (w_wr_mask) r_mask <= IO_DataW[NUM_SRC-1:0];
      if (IO_EnR) begin
        r_hit    <= w_hit;
        r_data_r <= w_hit ? w_rdata : '0;
      end
    end
  end

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      r_state       <= ST_IDLE;
      r_int_req     <= 1'b0;
      r_int_id      <= 1'b0;
      r_win         <= '0;
      r_cur_valid   <= 1'b0;
      r_cur_idx     <= '0;
      r_ret_service <= 1'b0;
    end else begin
      if (w_wr_eoi) r_cur_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_nmi_pend) begin
            r_state       <= ST_REQ_NMI;
            r_int_req     <= 1'b1;
            r_int_id      <= 1'b1;
            r_ret_service <= 1'b0;
          end else if (|w_act) begin
            r_state   <= ST_REQ_DEV;
            r_win     <= w_win;
            r_int_req <= 1'b1;
            r_int_id  <= 1'b0;
          end
        end
        ST_REQ_DEV: begin
          if (EIC_IntAck) begin
            r_state     <= ST_SERVICE;
            r_int_req   <= 1'b0;
            r_cur_valid <= 1'b1;
            r_cur_idx   <= r_win;
          end
        end
        ST_SERVICE: begin
          if (r_nmi_pend) begin
            r_state       <= ST_REQ_NMI;
            r_int_req     <= 1'b1;
            r_int_id      <= 1'b1;
            r_ret_service <= !w_wr_eoi;
          end else if (w_wr_eoi) begin
            r_state <= ST_IDLE;
          end
        end
        ST_REQ_NMI: begin
          if (w_wr_eoi) r_ret_service <= 1'b0;
          if (EIC_IntAck) begin
            r_state   <= (r_ret_service && !w_wr_eoi) ? ST_SERVICE : ST_IDLE;
            r_int_req <= 1'b0;
            r_int_id  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign IO_DataR    = r_data_r;
  assign IO_Hit      = r_hit;
  assign EIC_IntReq  = r_int_req;
  assign EIC_IntId   = r_int_id;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_external_interrupt_controller.sv
// Bench for external_interrupt_controller: bus decode table, directed handshake
// sequences, and randomised mask/pulse rounds against a transaction-level model.
module tb_external_interrupt_controller;

  localparam int          NSRC = 8;
  localparam logic [29:0] BASE = 30'h0000_0100;
  localparam logic [1:0]  S_IDLE = 2'd0, S_REQ_DEV = 2'd1, S_SERVICE = 2'd2, S_REQ_NMI = 2'd3;

  logic            clk, rst_n;
  logic [NSRC-1:0] src_irq;
  logic            nmi_irq, en_r, en_w, int_ack;
  logic [29:0]     addr;
  logic [31:0]     wdata, rdata;
  logic            hit, int_req, int_id;
  logic [1:0]      dbg;

  int errors = 0;
  int checks = 0;

  external_interrupt_controller #(.NUM_SRC(NSRC), .BASE_ADDR(BASE)) dut (
    .Sys_Clock(clk), .Sys_Reset(rst_n), .Src_Irq(src_irq), .Nmi_Irq(nmi_irq),
    .IO_EnR(en_r), .IO_EnW(en_w), .IO_Address(addr), .IO_DataW(wdata),
    .IO_DataR(rdata), .IO_Hit(hit), .EIC_IntReq(int_req), .EIC_IntId(int_id),
    .EIC_IntAck(int_ack), .o_dbg_state(dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [29:0] waddr;
    logic [31:0] wdat;
    logic [29:0] raddr;
    logic [31:0] exp_data;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_xfer(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] d);
    en_r = rd; en_w = wr; addr = a; wdata = d;
    tick();
    en_r = 1'b0; en_w = 1'b0;
  endtask

  task automatic bus_write(input logic [29:0] a, input logic [31:0] d);
    bus_xfer(1'b0, 1'b1, a, d);
  endtask

  task automatic read_chk(input string name, input logic [29:0] a, input logic [31:0] exp);
    bus_xfer(1'b1, 1'b0, a, 32'd0);
    check({name, "_hit"}, {31'd0, hit}, 32'd1);
    check(name, rdata, exp);
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  // Pulse the given sources for one cycle and wait until the request can be up.
  task automatic pulse_and_wait(input logic [NSRC-1:0] p);
    src_irq = p;
    tick();
    src_irq = '0;
    tick();
  endtask

  function automatic int lowest(input logic [NSRC-1:0] v);
    for (int i = 0; i < NSRC; i++) if (v[i]) return i;
    return 0;
  endfunction

  logic [NSRC-1:0] mp, mm, p, w1c, old_act;
  logic [31:0]     m;
  logic            exp_req;
  int              win;

  initial begin
    rst_n = 1'b0; src_irq = '0; nmi_irq = 1'b0; en_r = 1'b0; en_w = 1'b0;
    int_ack = 1'b0; addr = '0; wdata = '0;
    #22;
    check("rst_intreq", {31'd0, int_req}, 32'd0);
    check("rst_intid", {31'd0, int_id}, 32'd0);
    check("rst_hit", {31'd0, hit}, 32'd0);
    check("rst_datar", rdata, 32'd0);
    check("rst_state", {30'd0, dbg}, {30'd0, S_IDLE});
    rst_n = 1'b1;
    tick();

    // Bus decode table (IDLE, nothing pending).
    vecs[0] = '{1'b1, BASE + 30'd1, 32'h0000_01FF, BASE + 30'd1, 32'h0000_00FF, 1'b1};
    vecs[1] = '{1'b0, 30'd0, 32'd0, BASE + 30'd4, 32'd0, 1'b0};
    vecs[2] = '{1'b0, 30'd0, 32'd0, BASE - 30'd1, 32'd0, 1'b0};
    vecs[3] = '{1'b1, BASE + 30'd2, 32'hFFFF_FFFF, BASE + 30'd2, 32'd0, 1'b1};
    vecs[4] = '{1'b0, 30'd0, 32'd0, BASE + 30'd3, 32'd0, 1'b1};
    vecs[5] = '{1'b1, BASE + 30'd1, 32'h0000_005A, BASE + 30'd1, 32'h0000_005A, 1'b1};
    vecs[6] = '{1'b1, BASE, 32'h0000_00FF, BASE, 32'd0, 1'b1};
    vecs[7] = '{1'b0, 30'd0, 32'd0, BASE + 30'h1000_0000, 32'd0, 1'b0};
    vecs[8] = '{1'b1, BASE + 30'd1, 32'd0, BASE + 30'd1, 32'd0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].waddr, vecs[i].wdat);
      bus_xfer(1'b1, 1'b0, vecs[i].raddr, 32'd0);
      check($sformatf("vec%0d_hit", i), {31'd0, hit}, {31'd0, vecs[i].exp_hit});
      if (vecs[i].exp_hit) check($sformatf("vec%0d_data", i), rdata, vecs[i].exp_data);
    end

    // First request: source 2 with MASK=0x0F.
    bus_write(BASE + 30'd1, 32'h0F);
    src_irq = 8'h04;
    tick();
    src_irq = '0;
    check("first_req_early", {31'd0, int_req}, 32'd0);
    tick();
    check("first_req", {30'd0, int_id, int_req}, 32'd1);
    do_ack();
    check("first_req_drop", {31'd0, int_req}, 32'd0);
    read_chk("first_pend", BASE, 32'd0);
    read_chk("first_cur", BASE + 30'd2, 32'h8000_0002);
    bus_write(BASE + 30'd3, 32'd0);
    check("first_eoi_state", {30'd0, dbg}, {30'd0, S_IDLE});

    // Priority and stability: 5 requested, then 1 arrives before the ack.
    bus_write(BASE + 30'd1, 32'hFF);
    pulse_and_wait(8'h20);
    pulse_and_wait(8'h02);
    check("stab_req", {30'd0, int_id, int_req}, 32'd1);
    do_ack();
    read_chk("stab_cur", BASE + 30'd2, 32'h8000_0005);
    read_chk("stab_pend", BASE, 32'h02);
    bus_write(BASE + 30'd3, 32'd0);
    tick();
    check("stab_next_req", {30'd0, int_id, int_req}, 32'd1);
    do_ack();
    read_chk("stab_cur2", BASE + 30'd2, 32'h8000_0001);
    bus_write(BASE + 30'd3, 32'd0);

    // NMI pre-emption while servicing source 3.
    pulse_and_wait(8'h08);
    do_ack();
    nmi_irq = 1'b1;
    tick();
    nmi_irq = 1'b0;
    tick();
    check("nmi_req", {30'd0, int_id, int_req}, 32'd3);
    check("nmi_state", {30'd0, dbg}, {30'd0, S_REQ_NMI});
    do_ack();
    check("nmi_drop", {31'd0, int_req}, 32'd0);
    check("nmi_ret_state", {30'd0, dbg}, {30'd0, S_SERVICE});
    read_chk("nmi_cur", BASE + 30'd2, 32'h8000_0003);
    bus_write(BASE + 30'd3, 32'd0);

    // Masking and W1C.
    bus_write(BASE + 30'd1, 32'd0);
    pulse_and_wait(8'h10);
    read_chk("mask_pend", BASE, 32'h10);
    check("mask_noreq", {31'd0, int_req}, 32'd0);
    bus_write(BASE, 32'h10);
    read_chk("w1c_pend", BASE, 32'd0);
    src_irq = 8'h10;
    bus_write(BASE, 32'h10);
    src_irq = '0;
    read_chk("w1c_vs_edge", BASE, 32'h10);
    bus_write(BASE, 32'h10);

    // Spurious ack in IDLE.
    do_ack();
    check("spur_state", {30'd0, dbg}, {30'd0, S_IDLE});
    check("spur_req", {31'd0, int_req}, 32'd0);

    // Read and write together: read returns the pre-write value.
    bus_xfer(1'b1, 1'b1, BASE + 30'd1, 32'h33);
    check("rw_old", rdata, 32'd0);
    read_chk("rw_new", BASE + 30'd1, 32'h33);

    // EOI in the cycle the SERVICE state first sees a pending NMI.
    bus_write(BASE + 30'd1, 32'h01);
    pulse_and_wait(8'h01);
    do_ack();
    nmi_irq = 1'b1;
    tick();
    nmi_irq = 1'b0;
    bus_write(BASE + 30'd3, 32'd0);
    check("eoi_nmi_state", {30'd0, dbg}, {30'd0, S_REQ_NMI});
    check("eoi_nmi_req", {30'd0, int_id, int_req}, 32'd3);
    do_ack();
    check("eoi_nmi_ret", {30'd0, dbg}, {30'd0, S_IDLE});
    read_chk("eoi_nmi_cur", BASE + 30'd2, 32'd0);
    bus_write(BASE + 30'd1, 32'd0);

    // Randomised rounds against the model.
    mp = '0;
    for (int it = 0; it < 30; it++) begin
      m  = $urandom;
      mm = m[NSRC-1:0];
      p  = NSRC'($urandom_range(0, 255));
      bus_write(BASE + 30'd1, m);
      src_irq = p;
      tick();
      src_irq = '0;
      tick();
      tick();
      old_act = mp & mm;
      win     = (old_act != '0) ? lowest(old_act) : lowest((mp | p) & mm);
      mp      = mp | p;
      exp_req = ((mp & mm) != '0);
      check($sformatf("rnd%0d_req", it), {31'd0, int_req}, {31'd0, exp_req});
      read_chk($sformatf("rnd%0d_pend", it), BASE, {24'd0, mp});
      if (exp_req) begin
        check($sformatf("rnd%0d_id", it), {31'd0, int_id}, 32'd0);
        do_ack();
        mp[win] = 1'b0;
        read_chk($sformatf("rnd%0d_cur", it), BASE + 30'd2, 32'h8000_0000 | 32'(win));
      end
      w1c = NSRC'($urandom_range(0, 255));
      bus_write(BASE, {24'hFFFFFF, w1c});
      mp = mp & ~w1c;
      read_chk($sformatf("rnd%0d_w1c", it), BASE, {24'd0, mp});
      bus_write(BASE + 30'd1, 32'd0);
      bus_write(BASE + 30'd3, 32'd0);
      check($sformatf("rnd%0d_idle", it), {30'd0, dbg}, {30'd0, S_IDLE});
    end

    // Reset dropped while a device request is outstanding.
    bus_write(BASE, 32'hFF);
    bus_write(BASE + 30'd1, 32'hFF);
    pulse_and_wait(8'h40);
    check("rstm_req", {31'd0, int_req}, 32'd1);
    read_chk("rstm_mask_before", BASE + 30'd1, 32'hFF);
    #3 rst_n = 1'b0;
    #1;
    check("rstm_intreq", {31'd0, int_req}, 32'd0);
    check("rstm_hit", {31'd0, hit}, 32'd0);
    check("rstm_state", {30'd0, dbg}, {30'd0, S_IDLE});
    #2 rst_n = 1'b1;
    tick();
    read_chk("rstm_mask", BASE + 30'd1, 32'd0);
    read_chk("rstm_pend", BASE, 32'd0);
    check("rstm_noreq", {31'd0, int_req}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/external_interrupt_controller.md
# external_interrupt_controller

Memory-mapped external interrupt controller for the Kabeta core. It collects up to 16 edge-triggered device interrupt lines and one non-maskable line, prioritises them, and runs the EIC_IntReq/EIC_IntId/EIC_IntAck handshake with the core interrupt unit. It sits on the core I/O bus, which carries the word address and the read/write strobes. Software uses that bus to mask sources, read the pending set, claim the current source and signal end-of-interrupt.

## Interface
- NUM_SRC, 8: number of device sources, 1..16.
- BASE_ADDR, 30'h0000_0100: word address of register 0. Registers occupy BASE_ADDR+0..+3.
- Sys_Clock  in  1  system clock; all state changes on the rising edge.
- Sys_Reset  in  1  reset, asynchronous, active-low.
- Src_Irq  in  NUM_SRC  device interrupt lines, synchronous to Sys_Clock, rising-edge sensitive.
- Nmi_Irq  in  1  non-maskable line, synchronous, rising-edge sensitive.
- IO_EnR  in  1  I/O read strobe.
- IO_EnW  in  1  I/O write strobe.
- IO_Address  in  30  I/O word address.
- IO_DataW  in  32  I/O write data.
- IO_DataR  out  32  registered read data.
- IO_Hit  out  1  registered; 1 when IO_DataR holds data from this block.
- EIC_IntReq  out  1  interrupt request to the core.
- EIC_IntId  out  1  request class: 0 = device, 1 = NMI.
- EIC_IntAck  in  1  acknowledge from the core.

## Operation
- **Edge detection.** One history flop per line, reset to 0. A rising edge on Src_Irq[i] sets PEND[i]; a rising edge on Nmi_Irq sets NMI_PEND. A line that is already high at reset release counts as an edge.
- **Registers** (offset from BASE_ADDR):
  - +0 PEND: read returns the pending bits. Write-1-to-clear.
  - +1 MASK: read/write. 1 = enabled. Reset value 0 (all masked).
  - +2 CUR: read-only. bit31 = in-service valid, bits[3:0] = claimed index, all other bits 0.
  - +3 EOI: any write clears the in-service state. Read returns 0.
  - Unimplemented bits ≥ NUM_SRC read 0 and ignore writes.
- **Priority.** NMI first, then the lowest device index among (PEND & MASK).
- **FSM states:**
  - IDLE:
    - NMI_PEND → REQ_NMI.
    - Else if (PEND & MASK) ≠ 0 → latch winner W, go to REQ_DEV.
  - REQ_DEV: IntReq=1, IntId=0. On IntAck=1: clear PEND[W], CUR={1,W}, go to SERVICE.
  - SERVICE: IntReq=0.
    - NMI_PEND → REQ_NMI, returning to SERVICE after ack.
    - EOI write → CUR valid cleared, go to IDLE.
  - REQ_NMI: IntReq=1, IntId=1. On IntAck=1: clear NMI_PEND, return to the saved state (IDLE or SERVICE). No EOI is needed for NMI.
- **Request stability.** Once IntReq rises, IntReq, IntId and W hold until acknowledged.
  - A newly pending higher-priority source does not re-arbitrate.
  - Clearing the mask bit or PEND bit of W does not withdraw the request.
  - An NMI arriving during REQ_DEV waits until that ack.
- **Spurious ack.** IntAck while not in a REQ state is ignored.
- **Simultaneous events on one bit:**
  - A set edge wins over a W1C clear.
  - A set edge wins over an ack clear, so the source stays pending.
  - An EOI write in the same cycle that an NMI goes pending: go to REQ_NMI and return to IDLE after its ack.
- **Bus accesses.**
  - Only a word address in BASE_ADDR..BASE_ADDR+3 counts as a hit.
  - IO_EnR and IO_EnW together on a hit: the write takes effect and the read returns the pre-write value.
  - A read has no side effects.
- **Reset**, asserted at any time, asynchronously forces:
  - state = IDLE;
  - PEND, NMI_PEND, MASK, CUR and the history flops = 0;
  - EIC_IntReq = EIC_IntId = 0;
  - IO_DataR = 0, IO_Hit = 0.

## Timing
- Latency from a source edge to the PEND bit: 1 cycle, since edge detection compares against the history flop. The PEND bit is set on the next edge.
- Latency from PEND set to IntReq: IDLE evaluates in the cycle after the PEND bit is set, and IntReq is asserted on the following edge.
- IntReq drops on the edge where IntAck=1 is sampled.
- Reads: IO_DataR and IO_Hit update on the edge where IO_EnR is asserted. The data is valid in the following cycle (WB) and is held until the next read. A read that misses clears IO_Hit.
- Writes take effect on the edge where IO_EnW is asserted.
- EOI in SERVICE returns to IDLE on the same edge. The next request can be asserted one edge later.
- No combinational path from any input to any output.

## Test plan
- **Reset and first request.** Reset, write MASK=0x0F, pulse Src_Irq[2]:
  - IntReq=1, IntId=0 two edges later;
  - ack → PEND=0, CUR=0x8000_0002;
  - EOI → IDLE.
- **Priority and stability.** Src_Irq[5] pending with IntReq up; assert Src_Irq[1] before the ack:
  - the ack still claims 5 (CUR=0x8000_0005);
  - after EOI, source 1 is requested next.
- **NMI pre-emption.** In SERVICE with source 3, pulse Nmi_Irq:
  - IntReq=1, IntId=1;
  - ack → back in SERVICE with CUR=0x8000_0003.
- **Masking and W1C.** Pulse Src_Irq[4] with MASK=0:
  - PEND=0x10, no IntReq;
  - write PEND=0x10 → PEND=0;
  - a W1C in the same cycle as a new edge on the same bit leaves PEND=0x10.
- **Spurious ack and bus decode.** IntAck while IDLE causes no state change. A read of BASE_ADDR+4 gives IO_Hit=0. A read of MASK after writing 0x1FF with NUM_SRC=8 returns 0xFF.
- **Reset mid-request.** Drop Sys_Reset while in REQ_DEV: IntReq, MASK and PEND are 0 immediately, with no clock edge.
